abuf_drain: RTL and testbench

//  Downstream of pe_array. Reads accumulation buffers out of the PE array, group by group and address by address.

---
 rtl/abuf_drain_pkg.sv | 55 +++++
 rtl/abuf_drain_fifo.sv | 66 ++++++
 rtl/abuf_drain.sv | 173 +++++++++++++++++
 tb/tb_abuf_drain.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/abuf_drain_pkg.sv
// Shared types and geometry for the accumulation-buffer drain path.
package abuf_drain_pkg;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned BATCH     = 2;
    localparam int unsigned RES_W     = 16;
    localparam int unsigned PE_NUM    = 32;
    localparam int unsigned BUF_DEPTH = 256;

    // Bits needed to index n items; never less than one.
    function automatic int unsigned bw(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned GRP_NUM = PE_NUM / 4;
    localparam int unsigned GRP_W   = bw(GRP_NUM);
    localparam int unsigned ADDR_W  = bw(BUF_DEPTH);
    localparam int unsigned LANE_W  = BATCH * RES_W;

    typedef logic [3:0][LANE_W-1:0] acc_word_t;

    typedef struct packed {
        logic             valid;
        logic [GRP_W-1:0] grp;
        logic             last;
    } drain_tag_t;

    typedef struct packed {
        acc_word_t        data;
        logic [GRP_W-1:0] grp;
        logic             last;
    } drain_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush,
        StDone
    } drain_state_e;

    // Clamp every signed RES_W element to zero when negative.
    function automatic acc_word_t relu(input acc_word_t w);
        acc_word_t r;
        r = w;
        for (int j = 0; j < 4; j++) begin
            for (int b = 0; b < int'(BATCH); b++) begin
                if (w[j][b*RES_W+RES_W-1]) begin
                    r[j][b*RES_W +: RES_W] = '0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/abuf_drain_fifo.sv
// Synchronous first-word-fall-through FIFO of drain entries with an occupancy count.
module abuf_drain_fifo
    import abuf_drain_pkg::*;
#(
    parameter int unsigned Depth = 8,
    localparam int unsigned CntW = $clog2(Depth + 1),
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  drain_entry_t    push_data_i,
    input  logic            pop_i,
    output drain_entry_t    head_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    drain_entry_t    mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            full;
    logic            pop;

    assign empty_o = (count_q == '0);
    assign full    = (count_q == CntW'(Depth));
    assign pop     = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CntW'(push_i) - CntW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Issue credits make overflow impossible; a full push without a pop is a design bug.
    assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full && !pop));

endmodule

// File: rtl/abuf_drain.sv
// Drains PE accumulation buffers group by group onto a valid/ready stream.
// Define ABUF_DRAIN_RELU_EN to clamp negative elements to zero at FIFO push.
module abuf_drain
    import abuf_drain_pkg::*;
#(
    parameter int unsigned PE_RD_LAT  = 2,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [GRP_W-1:0]  grp_last_i,
    input  logic [ADDR_W-1:0] addr_last_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [GRP_W-1:0]  rd_sel_o,
    output logic [ADDR_W-1:0] abuf_rd_addr_o,
    input  acc_word_t         abuf_rd_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output acc_word_t         m_data_o,
    output logic [GRP_W-1:0]  m_grp_o,
    output logic              m_last_o
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < PE_RD_LAT + 2) begin : g_depth_check
        $error("abuf_drain: FIFO_DEPTH must be >= PE_RD_LAT+2");
    end
    if (PE_RD_LAT < 1) begin : g_lat_check
        $error("abuf_drain: PE_RD_LAT must be >= 1");
    end

    drain_state_e             state_q, state_d;
    logic [GRP_W-1:0]         grp_q, grp_d;
    logic [ADDR_W-1:0]        addr_q, addr_d;
    logic [GRP_W-1:0]         grp_last_q, grp_last_d;
    logic [ADDR_W-1:0]        addr_last_q, addr_last_d;
    drain_tag_t [PE_RD_LAT:0] tag_q, tag_d;
    logic [GRP_W-1:0]         rd_sel_q;

    logic            issue;
    logic            at_last;
    logic            credit_ok;
    int unsigned     inflight;
    logic            push;
    logic            pop;
    drain_entry_t    push_entry;
    drain_entry_t    head;
    logic            empty;
    logic [CntW-1:0] fifo_count;

    // Credits count reads still in the tag pipe so a push always finds room.
    always_comb begin
        inflight = 0;
        for (int i = 0; i <= int'(PE_RD_LAT); i++) begin
            inflight = inflight + 32'(tag_q[i].valid);
        end
        credit_ok = (32'(fifo_count) + inflight) < FIFO_DEPTH;
    end

    assign at_last = (grp_q == grp_last_q) && (addr_q == addr_last_q);
    assign pop     = m_valid_o && m_ready_i;

    always_comb begin
        state_d     = state_q;
        grp_d       = grp_q;
        addr_d      = addr_q;
        grp_last_d  = grp_last_q;
        addr_last_d = addr_last_q;
        issue       = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d     = StRun;
                    grp_last_d  = grp_last_i;
                    addr_last_d = addr_last_i;
                    grp_d       = '0;
                    addr_d      = '0;
                end
            end
            StRun: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (at_last) begin
                        state_d = StFlush;
                        grp_d   = '0;
                        addr_d  = '0;
                    end else if (addr_q == addr_last_q) begin
                        addr_d = '0;
                        grp_d  = grp_q + 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            StFlush: begin
                if (pop && head.last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tag_d[0].valid = issue;
        tag_d[0].grp   = grp_q;
        tag_d[0].last  = issue && at_last;
        for (int i = 1; i <= int'(PE_RD_LAT); i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    // Stage PE_RD_LAT-1 lines up with the PE output; hold the select when idle.
    assign rd_sel_o = tag_q[PE_RD_LAT-1].valid ? tag_q[PE_RD_LAT-1].grp : rd_sel_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            grp_q       <= '0;
            addr_q      <= '0;
            grp_last_q  <= '0;
            addr_last_q <= '0;
            tag_q       <= '0;
            rd_sel_q    <= '0;
        end else begin
            state_q     <= state_d;
            grp_q       <= grp_d;
            addr_q      <= addr_d;
            grp_last_q  <= grp_last_d;
            addr_last_q <= addr_last_d;
            tag_q       <= tag_d;
            rd_sel_q    <= rd_sel_o;
        end
    end

    assign push = tag_q[PE_RD_LAT].valid;

    always_comb begin
`ifdef ABUF_DRAIN_RELU_EN
        push_entry.data = relu(abuf_rd_data_i);
`else
        push_entry.data = abuf_rd_data_i;
`endif
        push_entry.grp  = tag_q[PE_RD_LAT].grp;
        push_entry.last = tag_q[PE_RD_LAT].last;
    end

    abuf_drain_fifo #(
        .Depth(FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (push),
        .push_data_i(push_entry),
        .pop_i      (pop),
        .head_o     (head),
        .empty_o    (empty),
        .count_o    (fifo_count)
    );

    assign abuf_rd_addr_o = addr_q;
    assign busy_o         = (state_q == StRun) || (state_q == StFlush);
    assign done_o         = (state_q == StDone);
    assign m_valid_o      = !empty;
    assign m_data_o       = head.data;
    assign m_grp_o        = head.grp;
    assign m_last_o       = !empty && head.last;

endmodule

// File: tb/tb_abuf_drain.sv
// Self-checking bench for abuf_drain: PE array model, scoreboard queue and vector table.
module tb_abuf_drain;
    import abuf_drain_pkg::*;

    localparam int L = 2;
`ifdef ABUF_DRAIN_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [GRP_W-1:0]  grp_last_in;
    logic [ADDR_W-1:0] addr_last_in;
    logic              busy, done;
    logic [GRP_W-1:0]  rd_sel;
    logic [ADDR_W-1:0] abuf_rd_addr;
    acc_word_t         abuf_rd_data;
    logic              m_valid, m_ready, m_last;
    acc_word_t         m_data;
    logic [GRP_W-1:0]  m_grp;
    bit                neg_mode;

    always #5 clk = ~clk;

    abuf_drain #(
        .PE_RD_LAT (L),
        .FIFO_DEPTH(8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .grp_last_i    (grp_last_in),
        .addr_last_i   (addr_last_in),
        .busy_o        (busy),
        .done_o        (done),
        .rd_sel_o      (rd_sel),
        .abuf_rd_addr_o(abuf_rd_addr),
        .abuf_rd_data_i(abuf_rd_data),
        .m_valid_o     (m_valid),
        .m_ready_i     (m_ready),
        .m_data_o      (m_data),
        .m_grp_o       (m_grp),
        .m_last_o      (m_last)
    );

    // Element = {batch, grp, pe, addr}; neg mode plants -3 / 5 in PE 0.
    function automatic acc_word_t pe_word(input int g, input int a, input bit nb, input bit clamp);
        acc_word_t   w;
        logic [15:0] e;
        for (int j = 0; j < 4; j++) begin
            for (int b = 0; b < 2; b++) begin
                e = 16'((b << 13) | (g << 10) | (j << 8) | a);
                if (nb && j == 0) e = (b == 0) ? (clamp ? 16'd0 : 16'hFFFD) : 16'd5;
                w[j][b*16 +: 16] = e;
            end
        end
        return w;
    endfunction

    // PE array model: PE_RD_LAT address delay, then registered rd_sel mux.
    logic [ADDR_W-1:0] ap [L];
    always @(posedge clk) begin
        ap[0] <= abuf_rd_addr;
        for (int i = 1; i < L; i++) ap[i] <= ap[i-1];
        abuf_rd_data <= pe_word(int'(rd_sel), int'(ap[L-1]), neg_mode, 1'b0);
    end

    typedef struct {
        int g;
        int a;
        bit last;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, 128'(busy), 128'(0));
        chk({tag, "_done"}, 128'(done), 128'(0));
        chk({tag, "_rd_sel"}, 128'(rd_sel), 128'(0));
        chk({tag, "_rd_addr"}, 128'(abuf_rd_addr), 128'(0));
        chk({tag, "_m_valid"}, 128'(m_valid), 128'(0));
        chk({tag, "_m_last"}, 128'(m_last), 128'(0));
    endtask

    // mode 0: always ready; 1: 20-cycle stall after 2 words; 2: random 50 %.
    task automatic run_drain(input int gl, input int al, input int mode, input bit nb,
                             input bit restart, input int abort_at,
                             output int words, output int busy_cyc);
        int   cyc = 0;
        int   stall = 0;
        bit   seen_last = 0;
        bit   finished = 0;
        exp_t e;
        exp_q.delete();
        for (int g = 0; g <= gl; g++)
            for (int a = 0; a <= al; a++)
                exp_q.push_back('{g: g, a: a, last: (g == gl && a == al)});
        neg_mode = nb;
        words    = 0;
        busy_cyc = 0;
        @(posedge clk); #1;
        start        = 1'b1;
        grp_last_in  = GRP_W'(gl);
        addr_last_in = ADDR_W'(al);
        while (!finished && cyc < 20000) begin
            @(posedge clk); #1;
            cyc++;
            start = restart && (cyc == 3);
            if (cyc == 1) begin
                chk("busy_after_start", 128'(busy), 128'(1));
                grp_last_in  = GRP_W'($urandom);
                addr_last_in = ADDR_W'($urandom);
            end
            if (cyc == 3) begin
                grp_last_in  = '0;
                addr_last_in = '0;
            end
            case (mode)
                1: if (words >= 2 && stall < 20) begin m_ready = 1'b0; stall++; end
                   else m_ready = 1'b1;
                2: m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
            #1;
            if (busy) busy_cyc++;
            if (seen_last) begin
                chk("done_after_last", 128'(done), 128'(1));
                chk("busy_falls_with_done", 128'(busy), 128'(0));
                finished = 1;
            end else if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 128'(1), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    if (m_grp !== GRP_W'(e.g) || m_data !== pe_word(e.g, e.a, nb, RELU))
                        chk($sformatf("word_g%0d_a%0d", e.g, e.a),
                            {m_data[3:1], m_data[0][31:3], m_grp},
                            {pe_word(e.g, e.a, nb, RELU)[3:1],
                             pe_word(e.g, e.a, nb, RELU)[0][31:3], GRP_W'(e.g)});
                    else begin checks++; passes++; end
                    chk("m_last", 128'(m_last), 128'(e.last));
                end
                words++;
                if (m_last) seen_last = 1;
                if (words == abort_at) finished = 1;
            end
        end
        if (!finished) chk("drain_timeout", 128'(0), 128'(1));
        if (abort_at == 0) begin
            @(posedge clk); #2;
            chk("idle_done_low", 128'(done), 128'(0));
            chk("idle_m_valid", 128'(m_valid), 128'(0));
            chk("idle_rd_sel_hold", 128'(rd_sel), 128'(gl));
            chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        end
    endtask

    typedef struct {
        int gl;
        int al;
        int mode;
        bit neg;
        bit restart;
        int exp_words;
    } vec_t;

    initial begin
        vec_t vecs[4];
        int   words, busy_cyc;
        vecs[0] = '{gl: 1, al: 3,   mode: 0, neg: 0, restart: 1, exp_words: 8};
        vecs[1] = '{gl: 1, al: 3,   mode: 1, neg: 0, restart: 0, exp_words: 8};
        vecs[2] = '{gl: 7, al: 255, mode: 2, neg: 0, restart: 0, exp_words: 2048};
        vecs[3] = '{gl: 0, al: 3,   mode: 0, neg: 1, restart: 0, exp_words: 4};

        rst = 1'b1; start = 1'b0; m_ready = 1'b0; neg_mode = 0;
        grp_last_in = '0; addr_last_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_drain(vecs[i].gl, vecs[i].al, vecs[i].mode, vecs[i].neg, vecs[i].restart, 0,
                      words, busy_cyc);
            chk($sformatf("word_count_vec%0d", i), 128'(words), 128'(vecs[i].exp_words));
        end

        // Single word: busy spans issue, PE_RD_LAT+1 capture cycles and the handshake.
        run_drain(0, 0, 0, 0, 0, 0, words, busy_cyc);
        chk("degenerate_words", 128'(words), 128'(1));
        chk("degenerate_busy_len", 128'(busy_cyc), 128'(L + 3));

        // Reset in the middle of a drain, then a clean restart.
        run_drain(1, 3, 0, 0, 0, 5, words, busy_cyc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state("mid_reset");
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_quiet", 128'(m_valid), 128'(0));
        run_drain(1, 3, 0, 0, 0, 0, words, busy_cyc);
        chk("post_reset_words", 128'(words), 128'(8));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
